// File: rtl/serv_csr_seq_pkg.sv
// Shared encodings for the CSR sequencer: CSR select and source codes,
// CSR addresses, funct3 operation codes and the sequencer state type.
package serv_csr_seq_pkg;

  // CSR select codes presented to the serial CSR file
  localparam logic [2:0] CSR_SEL_MSCRATCH = 3'd0;
  localparam logic [2:0] CSR_SEL_MTVEC    = 3'd1;
  localparam logic [2:0] CSR_SEL_MEPC     = 3'd2;
  localparam logic [2:0] CSR_SEL_MCAUSE   = 3'd3;
  localparam logic [2:0] CSR_SEL_MTVAL    = 3'd4;

  // Source of the bit written back into the selected CSR
  localparam logic [1:0] CSR_SOURCE_EXT = 2'd0;  // operand replaces CSR
  localparam logic [1:0] CSR_SOURCE_SET = 2'd1;  // CSR | operand
  localparam logic [1:0] CSR_SOURCE_CLR = 2'd2;  // CSR & ~operand
  localparam logic [1:0] CSR_SOURCE_CSR = 2'd3;  // recirculate unchanged

  // Machine-mode CSR addresses handled by this sequencer
  localparam logic [11:0] CSR_ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_ADDR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_ADDR_MTVAL    = 12'h343;

  // funct3[1:0] selects the operation; funct3[2] selects the immediate form
  localparam logic [1:0] F3_OP_NONE = 2'b00;
  localparam logic [1:0] F3_OP_RW   = 2'b01;
  localparam logic [1:0] F3_OP_RS   = 2'b10;
  localparam logic [1:0] F3_OP_RC   = 2'b11;
  localparam int         F3_IMM_BIT = 2;

  // Width of the zimm / rs1 index field
  localparam int ZIMM_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [2:0] sel;
    logic [1:0] source;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/serv_csr_seq_decode.sv
// Combinational decode of a CSR instruction into CSR select, write source
// and an illegal flag for unknown addresses or reserved funct3 values.
module serv_csr_decode
  import serv_csr_seq_pkg::*;
(
  input  logic [11:0] csr_addr,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1_addr,
  output logic [2:0]  sel,
  output logic [1:0]  source,
  output logic        illegal
);

  logic addr_ok;

  // Address and operation decode
  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    sel     = CSR_SEL_MTVEC;
    source  = CSR_SOURCE_CSR;
    addr_ok = 1'b1;

    case (csr_addr)
      CSR_ADDR_MTVEC:    sel = CSR_SEL_MTVEC;
      CSR_ADDR_MSCRATCH: sel = CSR_SEL_MSCRATCH;
      CSR_ADDR_MEPC:     sel = CSR_SEL_MEPC;
      CSR_ADDR_MCAUSE:   sel = CSR_SEL_MCAUSE;
      CSR_ADDR_MTVAL:    sel = CSR_SEL_MTVAL;
      default:           addr_ok = 1'b0;
    endcase

    case (funct3[1:0])
      F3_OP_RW: source = CSR_SOURCE_EXT;
      F3_OP_RS: source = CSR_SOURCE_SET;
      F3_OP_RC: source = CSR_SOURCE_CLR;
      default:  source = CSR_SOURCE_CSR;
    endcase

    // Set/clear with x0 (or zimm 0) is a pure read: leave the CSR untouched
    if ((funct3[1:0] == F3_OP_RS || funct3[1:0] == F3_OP_RC) && rs1_addr == '0) begin
      source = CSR_SOURCE_CSR;
    end

    illegal = !addr_ok || (funct3[1:0] == F3_OP_NONE);
  end

endmodule

// File: rtl/serv_csr_seq.sv
// CSR sequencer: accepts one CSR instruction or trap request, then runs a
// single W-cycle serial pass through the CSR file, shifting the operand out
// LSB first and collecting the old CSR value, and reports it with o_done.
module serv_csr_seq
  import serv_csr_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_csr_req,
  input  logic         i_trap_req,
  input  logic [11:0]  i_csr_addr,
  input  logic [2:0]   i_funct3,
  input  logic [4:0]   i_rs1_addr,
  input  logic [W-1:0] i_rs1_data,
  input  logic [3:0]   i_trap_cause,
  input  logic         i_pc,
  input  logic         i_mtval,
  input  logic         i_csr_q,
  output logic         o_csr_en,
  output logic [2:0]   o_csr_sel,
  output logic [1:0]   o_csr_source,
  output logic         o_trap,
  output logic [3:0]   o_mcause,
  output logic         o_csr_d,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_illegal,
  output logic [W-1:0] o_rdata
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_e         state;
  state_e         state_nxt;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   operand;
  logic [W-1:0]   operand_init;
  logic           accept_trap;
  logic           accept_csr;
  logic           reject;
  decode_t        dec;

  serv_csr_decode u_decode (
    .csr_addr (i_csr_addr),
    .funct3   (i_funct3),
    .rs1_addr (i_rs1_addr),
    .sel      (dec.sel),
    .source   (dec.source),
    .illegal  (dec.illegal)
  );

  // Immediate forms use the zero-extended rs1 index as the operand
  assign operand_init = i_funct3[F3_IMM_BIT] ? {{(W - ZIMM_W){1'b0}}, i_rs1_addr} : i_rs1_data;

  // Next-state logic and request arbitration (trap wins over CSR)
  always_comb begin
    state_nxt   = state;
    accept_trap = 1'b0;
    accept_csr  = 1'b0;
    reject      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_trap_req) begin
          accept_trap = 1'b1;
          state_nxt   = ST_RUN;
        end else if (i_csr_req) begin
          if (dec.illegal) begin
            reject = 1'b1;
          end else begin
            accept_csr = 1'b1;
            state_nxt  = ST_RUN;
          end
        end
      end
      ST_RUN:  if (cnt == CNT_LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs, counter and shift registers
  // NOTE: the shift registers are reset too, because o_rdata and o_csr_d have defined reset values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_csr_en     <= 1'b0;
      o_csr_sel    <= CSR_SEL_MTVEC;
      o_csr_source <= CSR_SOURCE_CSR;
      o_trap       <= 1'b0;
      o_mcause     <= '0;
      o_csr_d      <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_illegal    <= 1'b0;
      o_rdata      <= '0;
      operand      <= '0;
      cnt          <= '0;
    end else begin
      o_done    <= 1'b0;
      o_illegal <= reject;

      if (accept_trap) begin
        // mtvec recirculates while the CSR file loads mepc/mtval from i_pc/i_mtval
        o_mcause     <= i_trap_cause;
        o_csr_sel    <= CSR_SEL_MTVEC;
        o_csr_source <= CSR_SOURCE_CSR;
        o_trap       <= 1'b1;
        operand      <= '0;
        o_csr_d      <= 1'b0;
        o_csr_en     <= 1'b1;
        o_busy       <= 1'b1;
        cnt          <= '0;
      end else if (accept_csr) begin
        // Bit 0 goes out during the first RUN cycle; the rest is pre-shifted
        o_csr_sel    <= dec.sel;
        o_csr_source <= dec.source;
        o_trap       <= 1'b0;
        operand      <= operand_init >> 1;
        o_csr_d      <= operand_init[0];
        o_csr_en     <= 1'b1;
        o_busy       <= 1'b1;
        cnt          <= '0;
      end

      if (state == ST_RUN) begin
        o_csr_d <= operand[0];
        operand <= operand >> 1;
        o_rdata <= {i_csr_q, o_rdata[W-1:1]};
        cnt     <= cnt + CW'(1);
        if (cnt == CNT_LAST) begin
          o_csr_en <= 1'b0;
          o_trap   <= 1'b0;
          o_csr_d  <= 1'b0;
          o_done   <= 1'b1;
        end
      end

      if (state == ST_DONE) begin
        o_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serv_csr_seq.sv
// Directed bench for serv_csr_seq: a small serial CSR file model answers
// i_csr_q and applies the write source, a vector table drives single
// transactions, and hand-written sequences cover back-to-back requests
// and reset in the middle of a pass.
module tb_serv_csr_seq;
  import serv_csr_seq_pkg::*;

  localparam int W = 32;

  logic         i_clk;
  logic         i_rst;
  logic         i_csr_req;
  logic         i_trap_req;
  logic [11:0]  i_csr_addr;
  logic [2:0]   i_funct3;
  logic [4:0]   i_rs1_addr;
  logic [W-1:0] i_rs1_data;
  logic [3:0]   i_trap_cause;
  logic         i_pc;
  logic         i_mtval;
  logic         i_csr_q;
  logic         o_csr_en;
  logic [2:0]   o_csr_sel;
  logic [1:0]   o_csr_source;
  logic         o_trap;
  logic [3:0]   o_mcause;
  logic         o_csr_d;
  logic         o_busy;
  logic         o_done;
  logic         o_illegal;
  logic [W-1:0] o_rdata;

  serv_csr_seq #(.W(W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_csr_req    (i_csr_req),
    .i_trap_req   (i_trap_req),
    .i_csr_addr   (i_csr_addr),
    .i_funct3     (i_funct3),
    .i_rs1_addr   (i_rs1_addr),
    .i_rs1_data   (i_rs1_data),
    .i_trap_cause (i_trap_cause),
    .i_pc         (i_pc),
    .i_mtval      (i_mtval),
    .i_csr_q      (i_csr_q),
    .o_csr_en     (o_csr_en),
    .o_csr_sel    (o_csr_sel),
    .o_csr_source (o_csr_source),
    .o_trap       (o_trap),
    .o_mcause     (o_mcause),
    .o_csr_d      (o_csr_d),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_illegal    (o_illegal),
    .o_rdata      (o_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Serial CSR file model indexed by CSR_SEL_* code
  logic [W-1:0] m_csr [5];
  logic         model_load;

  assign i_csr_q = (o_csr_sel < 3'd5) ? m_csr[o_csr_sel][0] : 1'b0;

  function automatic logic write_bit(input logic [1:0] src, input logic q, input logic d);
    case (src)
      CSR_SOURCE_EXT: write_bit = d;
      CSR_SOURCE_SET: write_bit = q | d;
      CSR_SOURCE_CLR: write_bit = q & ~d;
      default:        write_bit = q;
    endcase
  endfunction

  always @(posedge i_clk) begin
    if (model_load) begin
      m_csr[0] <= 32'h12345678;  // mscratch
      m_csr[1] <= 32'h80000100;  // mtvec
      m_csr[2] <= 32'h0000040C;  // mepc
      m_csr[3] <= 32'h00000000;  // mcause
      m_csr[4] <= 32'hCAFEF00D;  // mtval
    end else if (o_csr_en) begin
      if (o_csr_sel < 3'd5)
        m_csr[o_csr_sel] <= {write_bit(o_csr_source, i_csr_q, o_csr_d), m_csr[o_csr_sel][W-1:1]};
      if (o_trap) begin
        m_csr[2] <= {i_pc, m_csr[2][W-1:1]};
        m_csr[4] <= {i_mtval, m_csr[4][W-1:1]};
      end
    end
  end

  typedef struct {
    logic        trap;
    logic [2:0]  funct3;
    logic [11:0] addr;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data;
    logic [3:0]  cause;
    logic [31:0] pc_word;
    logic [31:0] mtval_word;
    logic        exp_illegal;
    logic [2:0]  exp_sel;
    logic [1:0]  exp_src;
    logic [31:0] exp_d;
    logic [31:0] exp_rdata;
    int          final_idx;
    logic [31:0] exp_final;
  } vec_t;

  vec_t vecs [9];

  // Per-transaction observations
  int          en_cnt;
  int          done_cyc;
  int          illegal_cnt;
  int          illegal_at1;
  int          sel_bad;
  int          src_bad;
  int          trap_bad;
  int          mcause_bad;
  int          busy_bad;
  logic [31:0] d_word;
  logic [31:0] rdata_at_done;
  logic        en_at_done;

  task automatic run_txn(input vec_t v);
    en_cnt = 0; done_cyc = 0; illegal_cnt = 0; illegal_at1 = 0;
    sel_bad = 0; src_bad = 0; trap_bad = 0; mcause_bad = 0; busy_bad = 0;
    d_word = '0; rdata_at_done = '0; en_at_done = 1'b0;
    @(negedge i_clk);
    i_csr_req    = 1'b1;
    i_trap_req   = v.trap;
    i_csr_addr   = v.addr;
    i_funct3     = v.funct3;
    i_rs1_addr   = v.rs1_addr;
    i_rs1_data   = v.rs1_data;
    i_trap_cause = v.cause;
    @(negedge i_clk);
    i_csr_req  = 1'b0;
    i_trap_req = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (o_illegal) begin
        illegal_cnt++;
        if (cyc == 1) illegal_at1 = 1;
      end
      if (o_done) begin
        done_cyc      = cyc;
        rdata_at_done = o_rdata;
        en_at_done    = o_csr_en;
        break;
      end
      if (o_csr_en) begin
        if (en_cnt < W) d_word[en_cnt] = o_csr_d;
        if (o_csr_sel !== v.exp_sel) sel_bad++;
        if (o_csr_source !== v.exp_src) src_bad++;
        if (o_trap !== v.trap) trap_bad++;
        if (v.trap && o_mcause !== v.cause) mcause_bad++;
        if (o_busy !== 1'b1) busy_bad++;
        if (en_cnt < W) begin
          i_pc    = v.pc_word[en_cnt];
          i_mtval = v.mtval_word[en_cnt];
        end
        en_cnt++;
      end
      @(negedge i_clk);
    end
  endtask

  int          b2b_done1;
  int          b2b_done2;
  int          b2b_en2;
  logic [31:0] b2b_rdata1;
  logic [31:0] b2b_rdata2;
  int          rst_en_cnt;
  int          post_rst_done;
  int          post_rst_en;

  initial begin
    // trap, f3, addr, rs1, rs1_data, cause, pc, mtval, ill, sel, src, d, rdata, idx, final
    vecs[0] = '{1'b0, 3'b001, 12'h340, 5'd5, 32'hDEADBEEF, 4'h0, 32'h0, 32'h0,
                1'b0, CSR_SEL_MSCRATCH, CSR_SOURCE_EXT, 32'hDEADBEEF, 32'h12345678, 0, 32'hDEADBEEF};
    vecs[1] = '{1'b0, 3'b010, 12'h305, 5'd0, 32'h00000000, 4'h0, 32'h0, 32'h0,
                1'b0, CSR_SEL_MTVEC, CSR_SOURCE_CSR, 32'h00000000, 32'h80000100, 1, 32'h80000100};
    vecs[2] = '{1'b0, 3'b111, 12'h343, 5'h1F, 32'hFFFFFFFF, 4'h0, 32'h0, 32'h0,
                1'b0, CSR_SEL_MTVAL, CSR_SOURCE_CLR, 32'h0000001F, 32'hCAFEF00D, 4, 32'hCAFEF000};
    vecs[3] = '{1'b0, 3'b010, 12'h342, 5'd3, 32'h8000000A, 4'h0, 32'h0, 32'h0,
                1'b0, CSR_SEL_MCAUSE, CSR_SOURCE_SET, 32'h8000000A, 32'h00000000, 3, 32'h8000000A};
    vecs[4] = '{1'b0, 3'b011, 12'h341, 5'd7, 32'h0000000F, 4'h0, 32'h0, 32'h0,
                1'b0, CSR_SEL_MEPC, CSR_SOURCE_CLR, 32'h0000000F, 32'h0000040C, 2, 32'h00000400};
    vecs[5] = '{1'b0, 3'b110, 12'h340, 5'd0, 32'hFFFFFFFF, 4'h0, 32'h0, 32'h0,
                1'b0, CSR_SEL_MSCRATCH, CSR_SOURCE_CSR, 32'h00000000, 32'hDEADBEEF, 0, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 3'b001, 12'h340, 5'd5, 32'hFFFFFFFF, 4'hB, 32'h00001234, 32'h0BADC0DE,
                1'b0, CSR_SEL_MTVEC, CSR_SOURCE_CSR, 32'h00000000, 32'h80000100, 1, 32'h80000100};
    vecs[7] = '{1'b0, 3'b001, 12'h7C0, 5'd5, 32'h11111111, 4'h0, 32'h0, 32'h0,
                1'b1, CSR_SEL_MTVEC, CSR_SOURCE_CSR, 32'h0, 32'h0, 0, 32'hDEADBEEF};
    vecs[8] = '{1'b0, 3'b100, 12'h340, 5'd5, 32'h22222222, 4'h0, 32'h0, 32'h0,
                1'b1, CSR_SEL_MTVEC, CSR_SOURCE_CSR, 32'h0, 32'h0, 0, 32'hDEADBEEF};

    i_rst = 1'b1; i_csr_req = 1'b0; i_trap_req = 1'b0; i_csr_addr = '0; i_funct3 = '0;
    i_rs1_addr = '0; i_rs1_data = '0; i_trap_cause = '0; i_pc = 1'b0; i_mtval = 1'b0;
    model_load = 1'b1;
    repeat (3) @(negedge i_clk);
    model_load = 1'b0;

    check("rst_en",     {31'b0, o_csr_en},     32'd0);
    check("rst_busy",   {31'b0, o_busy},       32'd0);
    check("rst_done",   {31'b0, o_done},       32'd0);
    check("rst_rdata",  o_rdata,               32'd0);
    check("rst_sel",    {29'b0, o_csr_sel},    {29'b0, CSR_SEL_MTVEC});
    check("rst_source", {30'b0, o_csr_source}, {30'b0, CSR_SOURCE_CSR});
    check("rst_trap",   {31'b0, o_trap},       32'd0);
    check("rst_mcause", {28'b0, o_mcause},     32'd0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    check("idle_en",    {31'b0, o_csr_en},     32'd0);
    check("idle_busy",  {31'b0, o_busy},       32'd0);

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i]);
      check($sformatf("v%0d_illegal", i), illegal_cnt, {31'b0, vecs[i].exp_illegal});
      check($sformatf("v%0d_illegal_at1", i), illegal_at1, {31'b0, vecs[i].exp_illegal});
      if (vecs[i].exp_illegal) begin
        check($sformatf("v%0d_no_en", i),   en_cnt,   32'd0);
        check($sformatf("v%0d_no_done", i), done_cyc, 32'd0);
      end else begin
        check($sformatf("v%0d_en_cycles", i), en_cnt,   W);
        check($sformatf("v%0d_latency", i),   done_cyc, W + 1);
        check($sformatf("v%0d_d_stream", i),  d_word,   vecs[i].exp_d);
        check($sformatf("v%0d_rdata", i),     rdata_at_done, vecs[i].exp_rdata);
        check($sformatf("v%0d_en_at_done", i), {31'b0, en_at_done}, 32'd0);
        check($sformatf("v%0d_sel_bad", i),   sel_bad,  32'd0);
        check($sformatf("v%0d_src_bad", i),   src_bad,  32'd0);
        check($sformatf("v%0d_trap_bad", i),  trap_bad, 32'd0);
        check($sformatf("v%0d_busy_bad", i),  busy_bad, 32'd0);
        @(negedge i_clk);
        check($sformatf("v%0d_final_csr", i), m_csr[vecs[i].final_idx], vecs[i].exp_final);
        if (vecs[i].trap) begin
          check($sformatf("v%0d_mcause_bad", i), mcause_bad, 32'd0);
          check($sformatf("v%0d_mepc", i),  m_csr[2], 32'h00001234);
          check($sformatf("v%0d_mtval", i), m_csr[4], 32'h0BADC0DE);
          check($sformatf("v%0d_trap_after", i), {31'b0, o_trap}, 32'd0);
        end
      end
    end

    // Back-to-back: request held across a whole pass is accepted again only after DONE
    b2b_done1 = 0; b2b_done2 = 0; b2b_en2 = 0; b2b_rdata1 = '0; b2b_rdata2 = '0;
    @(negedge i_clk);
    i_csr_req = 1'b1; i_trap_req = 1'b0; i_csr_addr = 12'h340; i_funct3 = 3'b010;
    i_rs1_addr = 5'd0; i_rs1_data = '0;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(negedge i_clk);
      if (o_done && b2b_done1 == 0) begin
        b2b_done1 = cyc; b2b_rdata1 = o_rdata;
      end else if (o_done && b2b_done1 != 0) begin
        b2b_done2 = cyc; b2b_rdata2 = o_rdata;
        i_csr_req = 1'b0;
        break;
      end
      if (o_csr_en && b2b_done1 != 0 && b2b_en2 == 0) b2b_en2 = cyc;
    end
    i_csr_req = 1'b0;
    check("b2b_done1",  b2b_done1,  32'd33);
    check("b2b_en2",    b2b_en2,    32'd35);
    check("b2b_done2",  b2b_done2,  32'd67);
    check("b2b_rdata1", b2b_rdata1, 32'hDEADBEEF);
    check("b2b_rdata2", b2b_rdata2, 32'hDEADBEEF);
    repeat (3) @(negedge i_clk);
    check("b2b_idle_busy", {31'b0, o_busy}, 32'd0);

    // Reset during RUN cycle 10: immediate return to reset values, no done
    rst_en_cnt = 0; post_rst_done = 0; post_rst_en = 0;
    @(negedge i_clk);
    i_csr_req = 1'b1; i_csr_addr = 12'h340; i_funct3 = 3'b001;
    i_rs1_addr = 5'd9; i_rs1_data = 32'h5A5A5A5A;
    @(negedge i_clk);
    i_csr_req = 1'b0;
    for (int cyc = 0; cyc < 40 && rst_en_cnt < 10; cyc++) begin
      if (o_csr_en) rst_en_cnt++;
      if (rst_en_cnt < 10) @(negedge i_clk);
    end
    check("mid_en_cycles", rst_en_cnt, 32'd10);
    check("mid_busy_before", {31'b0, o_busy}, 32'd1);
    i_rst = 1'b1;
    #1;
    check("mid_rst_en",    {31'b0, o_csr_en}, 32'd0);
    check("mid_rst_busy",  {31'b0, o_busy},   32'd0);
    check("mid_rst_done",  {31'b0, o_done},   32'd0);
    check("mid_rst_rdata", o_rdata,           32'd0);
    check("mid_rst_sel",   {29'b0, o_csr_sel}, {29'b0, CSR_SEL_MTVEC});
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge i_clk);
      if (o_done) post_rst_done++;
      if (o_csr_en) post_rst_en++;
    end
    check("mid_no_done", post_rst_done, 32'd0);
    check("mid_no_en",   post_rst_en,   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
